instr_fetch_unit: RTL and testbench

//  Single-cycle MIPS instruction fetch: PC register, next-PC logic and 4 KB instruction ROM.

---
 rtl/instr_fetch_unit_if.sv | 29 ++
 rtl/instr_fetch_unit.sv | 71 +++++++
 tb/tb_instr_fetch_unit.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bundle: branch/jump controls from decode and ALU flags in,
// current instruction and link address out.
interface instr_fetch_unit_if;
  logic        Branch;
  logic        Jump;
  logic        Zero;
  logic        Sign;
  logic        OverFlow;
  logic        Rtype_J;
  logic [5:0]  OP;
  logic [4:0]  BranchFlag;
  logic [15:0] Imm16;
  logic [25:0] J_Target;
  logic [31:0] RJ_Addr;
  logic [31:0] Link_Addr;
  logic [31:0] Instruction;

  modport master (
    output Branch, Jump, Zero, Sign, OverFlow, Rtype_J,
    output OP, BranchFlag, Imm16, J_Target, RJ_Addr,
    input  Link_Addr, Instruction
  );

  modport slave (
    input  Branch, Jump, Zero, Sign, OverFlow, Rtype_J,
    input  OP, BranchFlag, Imm16, J_Target, RJ_Addr,
    output Link_Addr, Instruction
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Single-cycle MIPS fetch stage: word-addressed PC register, next-PC selection
// and a 1024-word combinational instruction ROM whose image is a parameter.
module instr_fetch_unit #(
  parameter logic [31:0]         RESET_PC = 32'h0000_3000,
  parameter logic [1023:0][31:0] IM_INIT  = '0
) (
  input logic               clk,
  input logic               rst_n,
  instr_fetch_unit_if.slave bus
);

  logic [29:0] r_pc;
  logic [29:0] w_pc4;
  logic [29:0] w_branchTarget;
  logic [29:0] w_next;
  logic        w_neg;
  logic        w_cond;
  logic        w_taken;
  logic        w_unused;

  assign w_pc4          = r_pc + 30'd1;
  assign w_neg          = bus.Sign ^ bus.OverFlow;
  assign w_branchTarget = w_pc4 + {{14{bus.Imm16[15]}}, bus.Imm16};

  // REGIMM (000001) picks bgez/bltz from the rt field; other opcodes never branch
  always_comb begin
    w_cond = 1'b0;
    case (bus.OP)
      6'b000100: w_cond = bus.Zero;
      6'b000101: w_cond = ~bus.Zero;
      6'b000110: w_cond = bus.Zero | w_neg;
      6'b000111: w_cond = ~bus.Zero & ~w_neg;
      6'b000001: begin
        if (bus.BranchFlag == 5'b00001) begin
          w_cond = ~w_neg;
        end else if (bus.BranchFlag == 5'b00000) begin
          w_cond = w_neg;
        end
      end
      default: w_cond = 1'b0;
    endcase
  end

  assign w_taken = bus.Branch & w_cond;

  always_comb begin
    w_next = w_pc4;
    if (bus.Rtype_J) begin
      w_next = bus.RJ_Addr[31:2];
    end else if (bus.Jump) begin
      w_next = {w_pc4[29:26], bus.J_Target};
    end else if (w_taken) begin
      w_next = w_branchTarget;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC[31:2];
    end else begin
      r_pc <= w_next;
    end
  end

  assign bus.Link_Addr   = {w_pc4, 2'b00};
  assign bus.Instruction = IM_INIT[r_pc[9:0]];

  // Register-jump targets are word aligned by construction; the low bits are dropped
  assign w_unused = &{1'b0, bus.RJ_Addr[1:0]};

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed fetch/branch/jump/reset
// cases followed by randomized control streams against a byte-address model.
module tb_instr_fetch_unit;

  typedef struct packed {
    logic        branch;
    logic        jump;
    logic        zero;
    logic        sign;
    logic        ovf;
    logic        rj;
    logic [5:0]  op;
    logic [4:0]  flag;
    logic [15:0] imm;
    logic [25:0] jt;
    logic [31:0] rja;
  } ctrl_t;

  function automatic logic [31:0] romWord(input logic [9:0] idx);
    return ({22'd0, idx} * 32'h9E37_79B1) ^ 32'hA5C3_0F1E;
  endfunction

  function automatic logic [1023:0][31:0] buildImage();
    logic [1023:0][31:0] img;
    for (int i = 0; i < 1024; i++) img[i] = romWord(i[9:0]);
    return img;
  endfunction

  localparam logic [1023:0][31:0] IMG = buildImage();

  logic  clk;
  logic  rst_n;
  ctrl_t curCtrl;
  logic [31:0] modelPc;
  int testCount;
  int failCount;

  instr_fetch_unit_if bus ();

  instr_fetch_unit #(
    .RESET_PC(32'h0000_3000),
    .IM_INIT (IMG)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Reference next-PC in byte addresses, straight from the branch/jump rules
  function automatic logic [31:0] nextPc(input logic [31:0] pc, input ctrl_t c);
    logic [31:0] seq;
    logic        neg;
    logic        taken;
    seq   = pc + 32'd4;
    neg   = c.sign ^ c.ovf;
    taken = 1'b0;
    if (c.branch) begin
      if (c.op == 6'd4)                       taken = c.zero;
      else if (c.op == 6'd5)                  taken = !c.zero;
      else if (c.op == 6'd6)                  taken = c.zero || neg;
      else if (c.op == 6'd7)                  taken = !c.zero && !neg;
      else if (c.op == 6'd1 && c.flag == 5'd1) taken = !neg;
      else if (c.op == 6'd1 && c.flag == 5'd0) taken = neg;
    end
    if (c.rj)        return c.rja & 32'hFFFF_FFFC;
    else if (c.jump) return (seq & 32'hF000_0000) | (32'(c.jt) * 32'd4);
    else if (taken)  return seq + 32'(int'($signed(c.imm)) * 4);
    else             return seq;
  endfunction

  task automatic applyStimulus(input ctrl_t c);
    curCtrl        = c;
    bus.Branch     = c.branch;
    bus.Jump       = c.jump;
    bus.Zero       = c.zero;
    bus.Sign       = c.sign;
    bus.OverFlow   = c.ovf;
    bus.Rtype_J    = c.rj;
    bus.OP         = c.op;
    bus.BranchFlag = c.flag;
    bus.Imm16      = c.imm;
    bus.J_Target   = c.jt;
    bus.RJ_Addr    = c.rja;
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, ".link"}, bus.Link_Addr, modelPc + 32'd4);
    checkOutput({tag, ".instr"}, bus.Instruction, romWord(modelPc[11:2]));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    modelPc = nextPc(modelPc, curCtrl);
    #1;
    checkModel(tag);
  endtask

  // Reset drops between edges so the PC change must be seen without a clock
  task automatic resetDut();
    rst_n = 1'b0;
    #1;
    checkOutput("rst.async", bus.Link_Addr, 32'h0000_3004);
    @(posedge clk);
    #1;
    checkOutput("rst.held", bus.Link_Addr, 32'h0000_3004);
    #2;
    rst_n   = 1'b1;
    modelPc = 32'h0000_3000;
  endtask

  function automatic ctrl_t randCtrl();
    ctrl_t c;
    c        = '0;
    c.branch = $urandom_range(0, 1) == 1;
    c.jump   = $urandom_range(0, 7) == 0;
    c.rj     = $urandom_range(0, 7) == 0;
    c.zero   = $urandom_range(0, 1) == 1;
    c.sign   = $urandom_range(0, 1) == 1;
    c.ovf    = $urandom_range(0, 3) == 0;
    case ($urandom_range(0, 7))
      0: c.op = 6'b000100;
      1: c.op = 6'b000101;
      2: c.op = 6'b000110;
      3: c.op = 6'b000111;
      4, 5: c.op = 6'b000001;
      6: c.op = 6'($urandom);
      default: c.op = 6'b000000;
    endcase
    c.flag = ($urandom_range(0, 3) == 0) ? 5'($urandom) : {4'd0, 1'($urandom)};
    c.imm  = 16'($urandom);
    c.jt   = 26'($urandom);
    c.rja  = $urandom;
    return c;
  endfunction

  initial begin
    ctrl_t c;
    testCount = 0;
    failCount = 0;
    clk       = 1'b0;
    rst_n     = 1'b0;
    modelPc   = 32'h0000_3000;
    applyStimulus('0);
    #12;
    checkOutput("reset.link", bus.Link_Addr, 32'h0000_3004);
    checkOutput("reset.instr", bus.Instruction, romWord(10'd0));
    #1;
    rst_n = 1'b1;

    tick("seq1");
    checkOutput("seq1.pc", bus.Link_Addr, 32'h0000_3008);
    checkOutput("seq1.rom", bus.Instruction, romWord(10'd1));
    tick("seq2");
    checkOutput("seq2.pc", bus.Link_Addr, 32'h0000_300C);

    resetDut();
    tick("pre.beq");
    c = '0; c.branch = 1'b1; c.op = 6'b000100; c.zero = 1'b1; c.imm = 16'hFFFE;
    applyStimulus(c);
    tick("beq.taken");
    checkOutput("beq.taken.pc", bus.Link_Addr, 32'h0000_3004);
    applyStimulus('0);
    tick("pre.beq2");
    c.zero = 1'b0;
    applyStimulus(c);
    tick("beq.nottaken");
    checkOutput("beq.nottaken.pc", bus.Link_Addr, 32'h0000_300C);

    resetDut();
    c = '0; c.branch = 1'b1; c.op = 6'b000001; c.flag = 5'd0;
    c.sign = 1'b0; c.ovf = 1'b1; c.imm = 16'd4;
    applyStimulus(c);
    tick("bltz");
    checkOutput("bltz.pc", bus.Link_Addr, 32'h0000_3018);

    resetDut();
    c = '0; c.jump = 1'b1; c.jt = 26'h000_0C10;
    applyStimulus(c);
    checkOutput("j.link", bus.Link_Addr, 32'h0000_3004);
    tick("j");
    checkOutput("j.pc", bus.Link_Addr, 32'h0000_3044);

    c = '0; c.jump = 1'b1; c.rj = 1'b1; c.jt = 26'h000_0C10; c.rja = 32'h0000_3100;
    applyStimulus(c);
    tick("jr.wins");
    checkOutput("jr.wins.pc", bus.Link_Addr, 32'h0000_3104);

    c = '0; c.jump = 1'b1; c.jt = 26'h000_1000;
    applyStimulus(c);
    tick("j.prerst");
    resetDut();
    applyStimulus('0);
    tick("post.rst");
    checkOutput("post.rst.pc", bus.Link_Addr, 32'h0000_3008);

    resetDut();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        resetDut();
      end
      applyStimulus(randCtrl());
      tick("rand");
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
